ysyx_24100012_mem_arbiter: RTL and testbench

- Shares the single DPI-backed RAM port (ysyx_24100012_ram: MemWEn, length, din, inaddr, outaddr, dout) between two requesters: IFU (instruction fetch, read-only) and LSU (load/store).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A fixed, parameterisable access latency models slow memory.
- Sits between the core's IFU/LSU and the RAM instance.

---
 rtl/ysyx_24100012_mem_arbiter_pkg.sv | 27 ++
 rtl/ysyx_24100012_mem_arbiter_if.sv | 58 +++++
 rtl/ysyx_24100012_mem_arbiter_rr_arb2.sv | 46 ++++
 rtl/ysyx_24100012_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ysyx_24100012_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100012_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: owner codes, FSM states, fixed fetch size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_24100012_mem_arbiter_pkg;

    // Requester identity as stored in the owner / last-grant registers.
    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // Instruction fetches are always full words.
    localparam int IFU_LEN = 4;

    // Counter width is sized for the largest legal access latency (15).
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The requester that wins a tie: whichever did not win last time.
    function automatic logic rr_pick(input logic last_grant);
        return (last_grant == OWNER_LSU) ? OWNER_IFU : OWNER_LSU;
    endfunction

endpackage

// File: rtl/ysyx_24100012_mem_arbiter_if.sv
// Bundle of the IFU request/response, LSU request/response and RAM-side signals of the arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request and both response channels; RAM side has none.
//
// Modports:
//   slave  - the arbiter: consumes requests, produces responses, drives the RAM port.
//   master - the environment: the core's IFU/LSU plus the RAM model returning mem_dout.
interface ysyx_24100012_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    // IFU channel (read-only)
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_addr;
    logic                  ifu_resp_valid;
    logic                  ifu_resp_ready;
    logic [DATA_WIDTH-1:0] ifu_rdata;

    // LSU channel (load/store)
    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic                  lsu_wen;
    logic [DATA_WIDTH-1:0] lsu_len;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic                  lsu_resp_valid;
    logic                  lsu_resp_ready;
    logic [DATA_WIDTH-1:0] lsu_rdata;

    // RAM port
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_length;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [ADDR_WIDTH-1:0] mem_inaddr;
    logic [ADDR_WIDTH-1:0] mem_outaddr;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_len, lsu_wdata, lsu_resp_ready,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_wen, mem_length, mem_din, mem_inaddr, mem_outaddr,
        input  mem_dout
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_len, lsu_wdata, lsu_resp_ready,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_wen, mem_length, mem_din, mem_inaddr, mem_outaddr,
        output mem_dout
    );

endinterface

// File: rtl/ysyx_24100012_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant (IFU vs LSU) with a last-grant register.
// Latency: grant is combinational from the requests; last-grant updates on the cycle after accept.
// Backpressure: none of its own; the caller pulses accept only when the grant is actually taken.
//
// Ports: clk, rst (sync, active-high), req_ifu/req_lsu requests, accept (grant consumed),
//        gnt_vld (some request present), gnt_owner (OWNER_IFU / OWNER_LSU).
module ysyx_24100012_rr_arb2
    import ysyx_24100012_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ifu,
    input  logic req_lsu,
    input  logic accept,
    output logic gnt_vld,
    output logic gnt_owner
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_vld   = req_ifu | req_lsu;
        gnt_owner = OWNER_IFU;
        if (req_ifu && req_lsu) begin
            gnt_owner = rr_pick(last_grant_q);
        end else if (req_lsu) begin
            gnt_owner = OWNER_LSU;
        end

        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = gnt_owner;
        end
    end

    // Reset to LSU so that the IFU wins the very first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWNER_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ysyx_24100012_mem_arbiter.sv
// Shares one combinational-read RAM port between IFU fetches and LSU loads/stores.
// Latency: request accepted at cycle t -> RAM access at t+LATENCY -> resp_valid from t+LATENCY+1.
// Backpressure: one access in flight; req_ready only in IDLE, response held until resp_ready.
//
// Ports: clk, rst (sync, active-high), bus (slave modport: IFU/LSU request+response channels
//        and the RAM port mem_wen/mem_length/mem_din/mem_inaddr/mem_outaddr/mem_dout).
// LATENCY must lie in 1..15.
module ysyx_24100012_mem_arbiter
    import ysyx_24100012_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_24100012_mem_arbiter_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] LAT_M1 = CNT_WIDTH'(LATENCY - 1);

    state_t                state_q,         state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,           cnt_d;
    logic                  owner_q,         owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,          addr_d;
    logic                  wen_q,           wen_d;
    logic [DATA_WIDTH-1:0] len_q,           len_d;
    logic [DATA_WIDTH-1:0] wdata_q,         wdata_d;
    logic                  mem_wen_q,       mem_wen_d;
    logic                  ifu_resp_vld_q,  ifu_resp_vld_d;
    logic                  lsu_resp_vld_q,  lsu_resp_vld_d;
    logic [DATA_WIDTH-1:0] ifu_rdata_q,     ifu_rdata_d;
    logic [DATA_WIDTH-1:0] lsu_rdata_q,     lsu_rdata_d;

    logic gnt_vld;
    logic gnt_owner;
    logic accept;
    logic resp_done;

    // A grant is only taken while idle; the arbiter's last-grant moves with it.
    assign accept = (state_q == S_IDLE) && gnt_vld;

    ysyx_24100012_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_ifu   (bus.ifu_req_valid),
        .req_lsu   (bus.lsu_req_valid),
        .accept    (accept),
        .gnt_vld   (gnt_vld),
        .gnt_owner (gnt_owner)
    );

    assign bus.ifu_req_ready = accept && (gnt_owner == OWNER_IFU);
    assign bus.lsu_req_ready = accept && (gnt_owner == OWNER_LSU);

    assign resp_done = (owner_q == OWNER_IFU) ? (ifu_resp_vld_q && bus.ifu_resp_ready)
                                              : (lsu_resp_vld_q && bus.lsu_resp_ready);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        len_d          = len_q;
        wdata_d        = wdata_q;
        mem_wen_d      = 1'b0;
        ifu_resp_vld_d = ifu_resp_vld_q;
        lsu_resp_vld_d = lsu_resp_vld_q;
        ifu_rdata_d    = ifu_rdata_q;
        lsu_rdata_d    = lsu_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d = gnt_owner;
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                    if (gnt_owner == OWNER_IFU) begin
                        addr_d  = bus.ifu_addr;
                        wen_d   = 1'b0;
                        len_d   = DATA_WIDTH'(IFU_LEN);
                        wdata_d = '0;
                    end else begin
                        addr_d  = bus.lsu_addr;
                        wen_d   = bus.lsu_wen;
                        len_d   = bus.lsu_len;
                        wdata_d = bus.lsu_wdata;
                    end
                    // With LATENCY == 1 the very next cycle is the access cycle,
                    // so the write strobe has to be armed right here.
                    mem_wen_d = (LAT_M1 == '0) && wen_d;
                end
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Access cycle: the RAM read is combinational, capture it now.
                    state_d = S_RESP;
                    if (owner_q == OWNER_IFU) begin
                        ifu_rdata_d    = bus.mem_dout;
                        ifu_resp_vld_d = 1'b1;
                    end else begin
                        lsu_rdata_d    = wen_q ? '0 : bus.mem_dout;
                        lsu_resp_vld_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    // Arm the registered strobe one cycle ahead so it is high
                    // during exactly the cycle where the counter reads zero.
                    mem_wen_d = (cnt_q == CNT_WIDTH'(1)) && wen_q;
                end
            end

            S_RESP: begin
                if (resp_done) begin
                    // No new grant this cycle: ready is only raised from IDLE.
                    state_d        = S_IDLE;
                    ifu_resp_vld_d = 1'b0;
                    lsu_resp_vld_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            owner_q        <= OWNER_IFU;
            addr_q         <= '0;
            wen_q          <= 1'b0;
            len_q          <= '0;
            wdata_q        <= '0;
            mem_wen_q      <= 1'b0;
            ifu_resp_vld_q <= 1'b0;
            lsu_resp_vld_q <= 1'b0;
            ifu_rdata_q    <= '0;
            lsu_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            wen_q          <= wen_d;
            len_q          <= len_d;
            wdata_q        <= wdata_d;
            mem_wen_q      <= mem_wen_d;
            ifu_resp_vld_q <= ifu_resp_vld_d;
            lsu_resp_vld_q <= lsu_resp_vld_d;
            ifu_rdata_q    <= ifu_rdata_d;
            lsu_rdata_q    <= lsu_rdata_d;
        end
    end

    // RAM inputs come straight from the latches so the combinational read
    // sees stable values for the whole transaction.
    assign bus.mem_wen     = mem_wen_q;
    assign bus.mem_length  = len_q;
    assign bus.mem_din     = wdata_q;
    assign bus.mem_inaddr  = addr_q;
    assign bus.mem_outaddr = addr_q;

    assign bus.ifu_resp_valid = ifu_resp_vld_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_resp_vld_q;
    assign bus.lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Bench for the memory arbiter: one instance at LATENCY=1, one at LATENCY=3, sharing a RAM model.
// Latency: n/a.
// Backpressure: response-ready is held low in one scenario to exercise response hold.
module tb_ysyx_24100012_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24100012_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
    ysyx_24100012_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

    ysyx_24100012_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (b1.slave));
    ysyx_24100012_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(3)) u_dut3 (
        .clk (clk), .rst (rst), .bus (b3.slave));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wen_cnt1 = 0;
    int wen_cnt3 = 0;
    logic [31:0] wen_len1 = 32'h0;
    bit mdl_last = 1'b1;                 // reference round-robin state of u_dut1 (1 = LSU)

    logic [31:0] ram [logic [29:0]];
    logic [31:0] q_exp [4][$];           // 0: ifu1, 1: lsu1, 2: ifu3, 3: lsu3

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [31:0] len);
        logic [31:0] w;
        w = ram.exists(a[31:2]) ? ram[a[31:2]] : 32'h0;
        w = w >> {a[1:0], 3'b000};
        if (len == 32'd1)      w = w & 32'h0000_00ff;
        else if (len == 32'd2) w = w & 32'h0000_ffff;
        return w;
    endfunction

    function automatic void ram_write(input logic [31:0] a, input logic [31:0] len, input logic [31:0] d);
        logic [31:0] w;
        int lane;
        w = ram.exists(a[31:2]) ? ram[a[31:2]] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            lane = int'(a[1:0]) + i;
            if (i < int'(len) && lane < 4) w[lane*8 +: 8] = d[i*8 +: 8];
        end
        ram[a[31:2]] = w;
    endfunction

    // RAM model, write strobes and scoreboard; all sampled away from the active edge.
    task automatic pop_chk(input int qi, input logic [31:0] got, input string tag);
        if (q_exp[qi].size() == 0) check_val({tag, "_unexpected_resp"}, 32'd1, 32'd0);
        else check_val(tag, got, q_exp[qi].pop_front());
    endtask

    always @(negedge clk) begin
        if (b1.mem_wen === 1'b1) begin
            ram_write(b1.mem_inaddr, b1.mem_length, b1.mem_din);
            wen_cnt1++;
            wen_len1 = b1.mem_length;
        end
        if (b3.mem_wen === 1'b1) begin
            ram_write(b3.mem_inaddr, b3.mem_length, b3.mem_din);
            wen_cnt3++;
        end
        b1.mem_dout = ram_read(b1.mem_outaddr, b1.mem_length);
        b3.mem_dout = ram_read(b3.mem_outaddr, b3.mem_length);
        if (b1.ifu_resp_valid && b1.lsu_resp_valid) check_val("both_resp_valid1", 32'd1, 32'd0);
        if (b1.ifu_resp_valid && b1.ifu_resp_ready) pop_chk(0, b1.ifu_rdata, "ifu1_rdata");
        if (b1.lsu_resp_valid && b1.lsu_resp_ready) pop_chk(1, b1.lsu_rdata, "lsu1_rdata");
        if (b3.ifu_resp_valid && b3.ifu_resp_ready) pop_chk(2, b3.ifu_rdata, "ifu3_rdata");
        if (b3.lsu_resp_valid && b3.lsu_resp_ready) pop_chk(3, b3.lsu_rdata, "lsu3_rdata");
    end

    task automatic set_req(input int d, input bit lsu, input bit v, input logic [31:0] a,
                           input bit w, input logic [31:0] len, input logic [31:0] wd);
        if (d == 1) begin
            if (lsu) begin
                b1.lsu_req_valid = v; b1.lsu_addr = a; b1.lsu_wen = w; b1.lsu_len = len; b1.lsu_wdata = wd;
            end else begin
                b1.ifu_req_valid = v; b1.ifu_addr = a;
            end
        end else begin
            if (lsu) begin
                b3.lsu_req_valid = v; b3.lsu_addr = a; b3.lsu_wen = w; b3.lsu_len = len; b3.lsu_wdata = wd;
            end else begin
                b3.ifu_req_valid = v; b3.ifu_addr = a;
            end
        end
    endtask

    function automatic bit req_rdy(input int d, input bit lsu);
        if (d == 1) return lsu ? b1.lsu_req_ready : b1.ifu_req_ready;
        return lsu ? b3.lsu_req_ready : b3.ifu_req_ready;
    endfunction

    function automatic bit resp_vld(input int d, input bit lsu);
        if (d == 1) return lsu ? b1.lsu_resp_valid : b1.ifu_resp_valid;
        return lsu ? b3.lsu_resp_valid : b3.ifu_resp_valid;
    endfunction

    // One isolated transaction on an idle arbiter; call just after a rising edge.
    task automatic xact(input int d, input bit lsu, input logic [31:0] a, input bit w,
                        input logic [31:0] len, input logic [31:0] wd,
                        input logic [31:0] exp, input int lat);
        int  t;
        int  waited;
        bit  got;
        q_exp[(d == 3 ? 2 : 0) + int'(lsu)].push_back(exp);
        set_req(d, lsu, 1'b1, a, w, len, wd);
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            waited++;
            got = req_rdy(d, lsu);
        end
        check_val("req_ready_first_cycle", 32'(waited), 32'd1);
        t = cyc;
        if (d == 1) mdl_last = lsu;
        @(posedge clk); #1;
        set_req(d, lsu, 1'b0, a, w, len, wd);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = resp_vld(d, lsu);
        end
        check_val("resp_valid_seen", 32'(got), 32'd1);
        check_val("resp_latency", 32'(cyc - t), 32'(lat));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q_exp[0].size() + q_exp[1].size() + q_exp[2].size() + q_exp[3].size()) != 0; i++)
            @(posedge clk);
        #1;
        check_val("scoreboard_drained",
                  32'(q_exp[0].size() + q_exp[1].size() + q_exp[2].size() + q_exp[3].size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w0;
        int  t;
        int  n;
        int  bad;
        bit  got;
        bit  ir;
        bit  lr;
        bit  exp_g;

        rst = 1'b1;
        set_req(1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        set_req(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        set_req(3, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        set_req(3, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        b1.ifu_resp_ready = 1'b1; b1.lsu_resp_ready = 1'b1;
        b3.ifu_resp_ready = 1'b1; b3.lsu_resp_ready = 1'b1;
        b1.mem_dout = 32'h0; b3.mem_dout = 32'h0;
        ram_write(32'h8000_0000, 32'd4, 32'h0000_0413);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ifu_resp_valid", 32'(b1.ifu_resp_valid), 32'd0);
        check_val("rst_lsu_resp_valid", 32'(b1.lsu_resp_valid), 32'd0);
        check_val("rst_mem_wen",        32'(b1.mem_wen),        32'd0);
        check_val("rst_ifu_rdata",      b1.ifu_rdata,           32'h0);
        check_val("rst_lsu_rdata",      b1.lsu_rdata,           32'h0);
        check_val("rst_mem_inaddr",     b1.mem_inaddr,          32'h0);
        check_val("rst_mem_length",     b1.mem_length,          32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // IFU alone: no write strobe, response two cycles after accept
        w0 = wen_cnt1;
        xact(1, 0, 32'h8000_0000, 0, 32'd4, 32'h0, 32'h0000_0413, 2);
        check_val("ifu_no_wen", 32'(wen_cnt1 - w0), 32'd0);

        // LSU store then load; store response data is zero
        w0 = wen_cnt1;
        xact(1, 1, 32'h8000_1000, 1, 32'd4, 32'hDEAD_BEEF, 32'h0, 2);
        check_val("store_wen_pulses", 32'(wen_cnt1 - w0), 32'd1);
        xact(1, 1, 32'h8000_1000, 0, 32'd4, 32'h0, 32'hDEAD_BEEF, 2);
        check_val("load_no_wen", 32'(wen_cnt1 - w0), 32'd1);

        // Both requesters valid every cycle: grants must alternate
        set_req(1, 0, 1, 32'h8000_0000, 0, 32'd4, 32'h0);
        set_req(1, 1, 1, 32'h8000_1000, 0, 32'd4, 32'h0);
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            ir = b1.ifu_req_ready;
            lr = b1.lsu_req_ready;
            if (ir || lr) begin
                exp_g = !mdl_last;
                check_val("rr_grant_is_lsu", 32'(lr), 32'(exp_g));
                check_val("rr_exclusive_ready", 32'(ir && lr), 32'd0);
                q_exp[int'(exp_g)].push_back(exp_g ? 32'hDEAD_BEEF : 32'h0000_0413);
                mdl_last = exp_g;
                n++;
            end
        end
        check_val("rr_grant_count", 32'(n), 32'd4);
        @(posedge clk); #1;
        set_req(1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        set_req(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        drain();

        // LATENCY=3, response held back for 5 cycles while the LSU waits
        b3.ifu_resp_ready = 1'b0;
        q_exp[2].push_back(32'h0000_0413);
        set_req(3, 0, 1, 32'h8000_0000, 0, 32'd4, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = b3.ifu_req_ready;
        end
        check_val("hold_req_ready", 32'(got), 32'd1);
        t = cyc;
        @(posedge clk); #1;
        set_req(3, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        set_req(3, 1, 1, 32'h8000_1000, 0, 32'd4, 32'h0);
        bad = 0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = b3.ifu_resp_valid;
            if (b3.lsu_req_ready) bad++;
        end
        check_val("hold_resp_latency", 32'(cyc - t), 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("hold_resp_valid", 32'(b3.ifu_resp_valid), 32'd1);
            check_val("hold_rdata_stable", b3.ifu_rdata, 32'h0000_0413);
            if (b3.lsu_req_ready || b3.ifu_req_ready) bad++;
        end
        check_val("hold_no_new_ready", 32'(bad), 32'd0);
        @(posedge clk); #1;
        b3.ifu_resp_ready = 1'b1;
        @(negedge clk);
        check_val("resp_hs_blocks_new_req", 32'(b3.lsu_req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("idle_accepts_waiting_lsu", 32'(b3.lsu_req_ready), 32'd1);
        q_exp[3].push_back(32'hDEAD_BEEF);
        @(posedge clk); #1;
        set_req(3, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        drain();

        // Reset while a LATENCY=3 store is still waiting
        ram_write(32'h8000_2000, 32'd4, 32'h1111_1111);
        w0 = wen_cnt3;
        set_req(3, 1, 1, 32'h8000_2000, 1, 32'd4, 32'hCAFE_F00D);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = b3.lsu_req_ready;
        end
        check_val("rst_store_ready", 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(3, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        mdl_last = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_mem_wen",     32'(b3.mem_wen),        32'd0);
        check_val("midrst_ifu_resp",    32'(b3.ifu_resp_valid), 32'd0);
        check_val("midrst_lsu_resp",    32'(b3.lsu_resp_valid), 32'd0);
        check_val("midrst_ifu_rdata",   b3.ifu_rdata,           32'h0);
        check_val("midrst_lsu_rdata",   b3.lsu_rdata,           32'h0);
        check_val("midrst_mem_inaddr",  b3.mem_inaddr,          32'h0);
        check_val("midrst_mem_outaddr", b3.mem_outaddr,         32'h0);
        check_val("midrst_mem_length",  b3.mem_length,          32'h0);
        check_val("midrst_mem_din",     b3.mem_din,             32'h0);
        repeat (6) @(negedge clk);
        check_val("midrst_no_write", 32'(wen_cnt3 - w0), 32'd0);
        @(posedge clk); #1;
        xact(3, 1, 32'h8000_2000, 0, 32'd4, 32'h0, 32'h1111_1111, 4);

        // Half-word store and readback
        w0 = wen_cnt1;
        xact(1, 1, 32'h8000_0010, 1, 32'd2, 32'h0000_ABCD, 32'h0, 2);
        check_val("half_wen_pulses", 32'(wen_cnt1 - w0), 32'd1);
        check_val("half_mem_length", wen_len1, 32'd2);
        xact(1, 1, 32'h8000_0010, 0, 32'd2, 32'h0, 32'h0000_ABCD, 2);

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
